spi_slave: RTL and testbench

- SPI target (slave) peripheral with the same simple register bus as the SPI master peripheral.
- Lets another device clock bytes in and out over the slave-side SPI pins.
- Samples SCK, CS and MOSI in the system clock domain and drives MISO.
- Has TX and RX byte FIFOs, programmable CPOL/CPHA and bit order, and a maskable IRQ.

---
 rtl/spi_slave_if.sv | 11 +
 rtl/spi_slave.sv | 215 +++++++++++++++++++++
 tb/tb_spi_slave.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_slave_if.sv
// Register bus between a host and the SPI target peripheral.
interface spi_slave_if;
    logic [4:0]  addr;
    logic        re;
    logic        we;
    logic [31:0] wd;
    logic [31:0] rd;

    modport master (output addr, re, we, wd, input rd);
    modport slave  (input addr, re, we, wd, output rd);
endinterface

// File: rtl/spi_slave.sv
// SPI target peripheral: synchronised SCK/CS/MOSI, TX/RX byte FIFOs,
// programmable CPOL/CPHA/bit order and a maskable, registered IRQ.
module spi_slave #(
    parameter int fifo_depth = 4
) (
    input  logic       clk,
    input  logic       rst,
    spi_slave_if.slave bus,
    output logic       irq,
    input  logic       spi_sck,
    input  logic       spi_cs,
    input  logic       spi_mosi,
    output logic       spi_miso,
    output logic       spi_miso_oe
);
    localparam int AW = $clog2(fifo_depth);
    localparam int CW = AW + 1;
    localparam int TW = (CW > 4) ? CW : 4;   // wide enough to hold 1<<3

    localparam logic [4:0] A_CR = 5'h00;
    localparam logic [4:0] A_SR = 5'h04;
    localparam logic [4:0] A_DR = 5'h08;
    localparam logic [4:0] A_IM = 5'h0C;
    localparam logic [4:0] A_IV = 5'h10;

    typedef enum logic {IDLE, ACTIVE} state_t;
    state_t state, state_nx;

    logic [7:0] cr;
    logic [4:0] irq_m, irq_v, irq_ev;
    logic       rx_ovf, tx_udf;
    logic       en, cpha, cpol, lsb;

    logic [1:0] sck_sync, cs_sync, mosi_sync;
    logic       sck_d, cs_d, sck_s, cs_s, mosi_s;
    logic       sck_rise, sck_fall, cs_rise, cs_fall;
    logic       lead_e, trail_e, sample_e, shift_e;

    logic       start, active;
    logic [2:0] bit_cnt;
    logic [7:0] rx_sh, tx_sh, rx_next;
    logic       samp, byte_done, tx_load, tx_shift;

    logic [7:0]    tx_mem [fifo_depth];
    logic [7:0]    rx_mem [fifo_depth];
    logic [AW-1:0] tx_wp, tx_rp, rx_wp, rx_rp;
    logic [CW-1:0] tx_cnt, rx_cnt;
    logic          tx_full, tx_empty, rx_full, rx_empty;
    logic          tx_push, tx_pop, rx_push, rx_pop;
    logic          ovf_ev, udf_ev;
    logic          rx_thr, tx_thr, rx_thr_d, tx_thr_d;
    logic          wr_cr, wr_sr, wr_im, wr_iv;
    logic          unused_wd;

    assign en   = cr[0];
    assign cpha = cr[1];
    assign cpol = cr[2];
    assign lsb  = cr[3];

    assign wr_cr = bus.we && (bus.addr == A_CR);
    assign wr_sr = bus.we && (bus.addr == A_SR);
    assign wr_im = bus.we && (bus.addr == A_IM);
    assign wr_iv = bus.we && (bus.addr == A_IV);
    assign unused_wd = ^bus.wd[31:8];

    // Two-flop synchronisers plus one delay stage for edge detection.
    // CS idles high, so its chain resets high to avoid a fake rising edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            sck_sync  <= 2'b00;
            cs_sync   <= 2'b11;
            mosi_sync <= 2'b00;
            sck_d     <= 1'b0;
            cs_d      <= 1'b1;
        end else begin
            sck_sync  <= {sck_sync[0], spi_sck};
            cs_sync   <= {cs_sync[0], spi_cs};
            mosi_sync <= {mosi_sync[0], spi_mosi};
            sck_d     <= sck_sync[1];
            cs_d      <= cs_sync[1];
        end
    end

    assign sck_s    = sck_sync[1];
    assign cs_s     = cs_sync[1];
    assign mosi_s   = mosi_sync[1];
    assign sck_rise = sck_s & ~sck_d;
    assign sck_fall = ~sck_s & sck_d;
    assign cs_rise  = cs_s & ~cs_d;
    assign cs_fall  = ~cs_s & cs_d;
    assign lead_e   = cpol ? sck_fall : sck_rise;
    assign trail_e  = cpol ? sck_rise : sck_fall;
    assign sample_e = cpha ? trail_e : lead_e;
    assign shift_e  = cpha ? lead_e : trail_e;

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // FSM next state; start marks the IDLE->ACTIVE transition.
    always_comb begin
        state_nx = state;
        start    = 1'b0;
        case (state)
            IDLE:    if (cs_fall && en) begin
                         state_nx = ACTIVE;
                         start    = 1'b1;
                     end
            ACTIVE:  if (cs_rise || !en) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign active    = (state == ACTIVE);
    assign samp      = active && sample_e;
    assign byte_done = samp && (bit_cnt == 3'd7);
    assign rx_next   = lsb ? {mosi_s, rx_sh[7:1]} : {rx_sh[6:0], mosi_s};
    // With cpha=0 the first byte is preloaded on CS; later bytes (and every
    // cpha=1 byte) load on the shift edge that starts a new byte.
    assign tx_load   = (start && !cpha) || (active && shift_e && bit_cnt == 3'd0);
    assign tx_shift  = active && shift_e && (bit_cnt != 3'd0);

    assign tx_full  = (tx_cnt == CW'(fifo_depth));
    assign tx_empty = (tx_cnt == '0);
    assign rx_full  = (rx_cnt == CW'(fifo_depth));
    assign rx_empty = (rx_cnt == '0);
    assign tx_push  = bus.we && (bus.addr == A_DR) && !tx_full;
    assign tx_pop   = tx_load && !tx_empty;
    assign udf_ev   = tx_load && tx_empty;
    assign rx_push  = byte_done && !rx_full;
    assign ovf_ev   = byte_done && rx_full;
    assign rx_pop   = bus.re && (bus.addr == A_DR) && !rx_empty;

    assign spi_miso_oe = active;
    assign spi_miso    = active && (lsb ? tx_sh[0] : tx_sh[7]);

    // Bit counter and shift registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt <= 3'd0;
            rx_sh   <= 8'h00;
            tx_sh   <= 8'h00;
        end else begin
            if (start)     bit_cnt <= 3'd0;
            else if (samp) bit_cnt <= bit_cnt + 3'd1;
            if (samp) rx_sh <= rx_next;
            if (tx_load)       tx_sh <= tx_empty ? 8'h00 : tx_mem[tx_rp];
            else if (tx_shift) tx_sh <= lsb ? {1'b0, tx_sh[7:1]} : {tx_sh[6:0], 1'b0};
        end
    end

    // FIFO storage (no reset needed; validity comes from the counts).
    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[tx_wp] <= bus.wd[7:0];
        if (rx_push) rx_mem[rx_wp] <= rx_next;
    end

    // FIFO pointers and counts; simultaneous push and pop cancel in the count.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_wp <= '0; tx_rp <= '0; tx_cnt <= '0;
            rx_wp <= '0; rx_rp <= '0; rx_cnt <= '0;
        end else begin
            if (tx_push) tx_wp <= tx_wp + 1'b1;
            if (tx_pop)  tx_rp <= tx_rp + 1'b1;
            if (rx_push) rx_wp <= rx_wp + 1'b1;
            if (rx_pop)  rx_rp <= rx_rp + 1'b1;
            tx_cnt <= tx_cnt + CW'(tx_push) - CW'(tx_pop);
            rx_cnt <= rx_cnt + CW'(rx_push) - CW'(rx_pop);
        end
    end

    assign rx_thr = TW'(rx_cnt) >= (TW'(1) << cr[5:4]);
    assign tx_thr = TW'(tx_cnt) <= (TW'(1) << cr[7:6]);
    assign irq_ev = {cs_rise, udf_ev, ovf_ev, tx_thr & ~tx_thr_d, rx_thr & ~rx_thr_d};

    // Control/status registers; events override a same-cycle clear.
    // Threshold history resets to the reset-state condition so no event fires.
    always_ff @(posedge clk) begin
        if (rst) begin
            cr       <= 8'h00;
            irq_m    <= 5'h00;
            irq_v    <= 5'h00;
            rx_ovf   <= 1'b0;
            tx_udf   <= 1'b0;
            irq      <= 1'b0;
            rx_thr_d <= 1'b0;
            tx_thr_d <= 1'b1;
        end else begin
            rx_thr_d <= rx_thr;
            tx_thr_d <= tx_thr;
            if (wr_cr) cr    <= bus.wd[7:0];
            if (wr_im) irq_m <= bus.wd[4:0];
            irq_v  <= (wr_iv ? bus.wd[4:0] : irq_v) | irq_ev;
            rx_ovf <= (rx_ovf & ~(wr_sr & bus.wd[5])) | ovf_ev;
            tx_udf <= (tx_udf & ~(wr_sr & bus.wd[6])) | udf_ev;
            irq    <= |(irq_v & irq_m);
        end
    end

    // Combinational register read mux.
    always_comb begin
        bus.rd = 32'h0;
        case (bus.addr)
            A_CR: bus.rd = {24'h0, cr};
            A_SR: bus.rd = {25'h0, tx_udf, rx_ovf, ~cs_s, rx_empty, rx_full, tx_empty, tx_full};
            A_DR: bus.rd = rx_empty ? 32'h0 : {24'h0, rx_mem[rx_rp]};
            A_IM: bus.rd = {27'h0, irq_m};
            A_IV: bus.rd = {27'h0, irq_v};
            default: bus.rd = 32'h0;
        endcase
    end
endmodule

// File: tb/tb_spi_slave.sv
// Bench for spi_slave: randomized SPI frames against a queue-level model,
// with a scoreboard checking bus reads and master-received MISO bytes.
module tb_spi_slave;
    localparam int DEPTH = 4;
    localparam int H     = 8;   // SCK half period in clk cycles
    localparam logic [4:0] A_CR = 5'h00, A_SR = 5'h04, A_DR = 5'h08,
                           A_IM = 5'h0C, A_IV = 5'h10;

    logic clk = 1'b0;
    logic rst, irq, spi_sck, spi_cs, spi_mosi, spi_miso, spi_miso_oe;

    spi_slave_if bif();

    spi_slave #(.fifo_depth(DEPTH)) dut (
        .clk(clk), .rst(rst), .bus(bif), .irq(irq),
        .spi_sck(spi_sck), .spi_cs(spi_cs), .spi_mosi(spi_mosi),
        .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [4:0]  a;
        logic [31:0] exp;
        logic [31:0] msk;
    } rd_exp_t;

    rd_exp_t    rd_q[$];
    logic [7:0] miso_q[$];
    logic [7:0] f_data[$];

    // Reference model state
    logic [7:0] m_tx[$], m_rx[$];
    bit m_ovf, m_udf, m_cpol, m_cpha, m_lsb;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] m_pop_tx();
        if (m_tx.size() == 0) begin
            m_udf = 1'b1;
            return 8'h00;
        end
        return m_tx.pop_front();
    endfunction

    function automatic logic [31:0] m_sr();
        return {25'h0, m_udf, m_ovf, 1'b0, m_rx.size() == 0, m_rx.size() == DEPTH,
                m_tx.size() == 0, m_tx.size() == DEPTH};
    endfunction

    task automatic tick(int n = 1);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic wr(logic [4:0] a, logic [31:0] d);
        bif.addr = a; bif.wd = d; bif.we = 1'b1;
        tick();
        bif.we = 1'b0;
    endtask

    task automatic rd_chk(logic [4:0] a, logic [31:0] exp, logic [31:0] msk);
        rd_exp_t e;
        e.a = a; e.exp = exp & msk; e.msk = msk;
        rd_q.push_back(e);
        bif.addr = a; bif.re = 1'b1;
        tick();
        bif.re = 1'b0;
    endtask

    task automatic rd_dr();
        logic [7:0] v;
        v = (m_rx.size() != 0) ? m_rx.pop_front() : 8'h00;
        rd_chk(A_DR, {24'h0, v}, 32'hFFFF_FFFF);
    endtask

    task automatic tx_write(logic [7:0] v);
        wr(A_DR, {24'h0, v});
        if (m_tx.size() < DEPTH) m_tx.push_back(v);
    endtask

    task automatic set_cr(bit cpol, bit cpha, bit lsb, logic [1:0] rxl);
        wr(A_CR, {24'h0, 2'b00, rxl, lsb, cpol, cpha, 1'b1});
        m_cpol = cpol; m_cpha = cpha; m_lsb = lsb;
        spi_sck = cpol;
        tick(4);
    endtask

    task automatic clr_flags();
        wr(A_SR, 32'h60);
        m_ovf = 1'b0; m_udf = 1'b0;
    endtask

    task automatic send_bit(logic b);
        if (!m_cpha) begin
            spi_mosi = b; tick(H);
            spi_sck = ~m_cpol; tick(H);
            spi_sck = m_cpol;
        end else begin
            spi_sck = ~m_cpol; spi_mosi = b; tick(H);
            spi_sck = m_cpol; tick(H);
        end
    endtask

    // One CS frame: nfull whole bytes from f_data, then part bits of the next.
    task automatic frame(int nfull, int part, bit drain);
        logic [7:0] cur, b;
        cur = 8'h00;
        spi_sck = m_cpol; spi_cs = 1'b0;
        tick(H);
        check("miso_oe_active", 32'(spi_miso_oe), 32'd1);
        if (!m_cpha) cur = m_pop_tx();
        for (int k = 0; k < nfull; k++) begin
            if (m_cpha) cur = m_pop_tx();
            miso_q.push_back(cur);
            b = f_data[k];
            for (int i = 0; i < 8; i++) send_bit(m_lsb ? b[i] : b[7-i]);
            if (m_rx.size() < DEPTH) m_rx.push_back(b);
            else m_ovf = 1'b1;
            if (!m_cpha) cur = m_pop_tx();
            if (drain) begin
                tick(4);
                rd_dr();
            end
        end
        if (part > 0) begin
            if (m_cpha) void'(m_pop_tx());
            b = f_data[nfull];
            for (int i = 0; i < part; i++) send_bit(m_lsb ? b[i] : b[7-i]);
        end
        tick(H);
        spi_cs = 1'b1;
        tick(6);
        check("miso_oe_idle", 32'(spi_miso_oe), 32'd0);
    endtask

    // Bus-read monitor: compares rd mid-cycle whenever re is asserted.
    initial begin
        rd_exp_t e;
        forever begin
            @(negedge clk);
            if (bif.re === 1'b1) begin
                if (rd_q.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL rd_unexpected: got 0x%0h expected no read", bif.rd);
                end else begin
                    e = rd_q.pop_front();
                    check($sformatf("rd_addr_%0h", e.a), bif.rd & e.msk, e.exp);
                end
            end
        end
    end

    // MISO monitor: assembles bytes on the master's sampling edges.
    initial begin
        logic prev;
        int cnt;
        logic [7:0] v;
        prev = 1'b0; cnt = 0; v = 8'h00;
        forever begin
            @(spi_sck or spi_cs);
            if (spi_cs) cnt = 0;
            else if (spi_sck !== prev) begin
                if ((m_cpha == 1'b0) == (spi_sck != m_cpol)) begin
                    if (m_lsb) v[cnt] = spi_miso;
                    else       v[7-cnt] = spi_miso;
                    cnt++;
                    if (cnt == 8) begin
                        cnt = 0;
                        if (miso_q.size() == 0) begin
                            n_tests++; n_fail++;
                            $display("FAIL miso_unexpected: got 0x%0h expected no byte", v);
                        end else
                            check("miso_byte", 32'(v), 32'(miso_q.pop_front()));
                    end
                end
            end
            prev = spi_sck;
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        string s;
        int n, k;
        rst = 1'b1; spi_sck = 1'b0; spi_cs = 1'b1; spi_mosi = 1'b0;
        bif.addr = 5'h0; bif.re = 1'b0; bif.we = 1'b0; bif.wd = 32'h0;
        m_ovf = 1'b0; m_udf = 1'b0; m_cpol = 1'b0; m_cpha = 1'b0; m_lsb = 1'b0;
        repeat (5) @(posedge clk);
        #2 rst = 1'b0;

        // Reset state
        check("rst_irq", 32'(irq), 32'd0);
        check("rst_miso_oe", 32'(spi_miso_oe), 32'd0);
        check("rst_miso", 32'(spi_miso), 32'd0);
        rd_chk(A_SR, 32'h0A, 32'hFFFF_FFFF);
        rd_chk(A_CR, 32'h00, 32'hFFFF_FFFF);
        rd_chk(5'h14, 32'h00, 32'hFFFF_FFFF);
        rd_chk(A_DR, 32'h00, 32'hFFFF_FFFF);
        set_cr(1'b0, 1'b0, 1'b0, 2'd0);
        rd_chk(A_CR, 32'h01, 32'hFFFF_FFFF);

        // Mode-0 loopback
        tx_write(8'h3C);
        f_data = '{8'hA5};
        frame(1, 0, 1'b0);
        rd_dr();
        rd_dr();                                  // empty: reads 0, no pop
        rd_chk(A_SR, m_sr(), 32'hFFFF_FFFF);
        clr_flags();

        // All four modes, LSB first, with TX underflow after four bytes
        s = "Hello World!\n";
        for (int m = 0; m < 4; m++) begin
            set_cr(m[1], m[0], 1'b1, 2'd0);
            for (int i = 0; i < 4; i++) tx_write(8'(i));
            f_data.delete();
            for (int i = 0; i < s.len(); i++) f_data.push_back(s[i]);
            frame(s.len(), 0, 1'b1);
            rd_chk(A_SR, m_sr(), 32'hFFFF_FFFF);
            clr_flags();
        end

        // RX threshold interrupt
        set_cr(1'b0, 1'b0, 1'b0, 2'd1);
        wr(A_IM, 32'h01);
        wr(A_IV, 32'h00);
        tick(2);
        f_data = '{8'(($urandom))};
        frame(1, 0, 1'b0);
        tick(2);
        check("irq_below_thr", 32'(irq), 32'd0);
        f_data = '{8'(($urandom))};
        frame(1, 0, 1'b0);
        tick(2);
        check("irq_at_thr", 32'(irq), 32'd1);
        wr(A_IV, 32'h00);
        tick();
        check("irq_cleared", 32'(irq), 32'd0);
        rd_dr();
        rd_dr();
        wr(A_IM, 32'h00);
        clr_flags();

        // RX overflow
        set_cr(1'b0, 1'b0, 1'b0, 2'd0);
        f_data.delete();
        for (int i = 0; i < 5; i++) f_data.push_back(8'($urandom));
        frame(5, 0, 1'b0);
        rd_chk(A_SR, m_sr(), 32'hFFFF_FFFF);
        for (int i = 0; i < 4; i++) rd_dr();
        wr(A_SR, 32'h20);
        m_ovf = 1'b0;
        rd_chk(A_SR, m_sr(), 32'hFFFF_FFFF);
        clr_flags();

        // CS abort mid-byte, then a clean byte
        wr(A_IV, 32'h00);
        f_data = '{8'(($urandom))};
        frame(0, 5, 1'b0);
        rd_chk(A_SR, m_sr(), 32'hFFFF_FFFF);
        rd_chk(A_IV, 32'h10, 32'h10);
        f_data = '{8'(($urandom))};
        frame(1, 0, 1'b1);
        rd_chk(A_SR, m_sr(), 32'hFFFF_FFFF);
        clr_flags();

        // Randomized frames
        for (int it = 0; it < 6; it++) begin
            set_cr(1'($urandom), 1'($urandom), 1'($urandom), 2'd0);
            k = $urandom_range(0, 3);
            for (int i = 0; i < k; i++) tx_write(8'($urandom));
            n = $urandom_range(1, 3);
            f_data.delete();
            for (int i = 0; i < n; i++) f_data.push_back(8'($urandom));
            frame(n, 0, 1'b1);
            rd_chk(A_SR, m_sr(), 32'hFFFF_FFFF);
            clr_flags();
        end

        tick(10);
        check("rd_queue_drained", 32'(rd_q.size()), 32'd0);
        check("miso_queue_drained", 32'(miso_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
